// File: rtl/axi_arb_pkg.sv
// ----------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and helpers for the AXI address-channel arbiters.
//   arb_mode_e      : arbitration policy (fixed priority, index 0 highest, or
//                     round-robin)
//   aw_arb_state_e  : write-address arbiter FSM states
//   onehot_to_idx() : index of the lowest set bit of a one-hot vector of up
//                     to MAX_MASTERS bits
// ----------------------------------------------------------------------------
package axi_arb_pkg;

    localparam int unsigned MAX_MASTERS = 16;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        AW_WAIT = 2'd1,
        W_WAIT  = 2'd2
    } aw_arb_state_e;

    // The scan runs from the top bit down, so the lowest set bit is the one
    // returned. For a true one-hot input, that is the only set bit.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational winner selection. The read-address arbiter reuses it.
//   req_i            in   NUM_REQ  request vector
//   ptr_i            in   IDX_W    round-robin start index (ignored in fixed mode)
//   mode_i           in   1        ARB_FIXED: lowest index wins
//                                  ARB_RR   : first request at or after ptr_i,
//                                             wrapping to index 0
//   winner_onehot_o  out  NUM_REQ  one-hot winner (zero when no request)
//   winner_idx_o     out  IDX_W    encoded winner
// ----------------------------------------------------------------------------
module rr_priority_picker
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  arb_mode_e          mode_i,
    output logic [NUM_REQ-1:0] winner_onehot_o,
    output logic [IDX_W-1:0]   winner_idx_o
);

    logic [NUM_REQ-1:0] mask_hi;
    logic [NUM_REQ-1:0] req_hi;
    logic [NUM_REQ-1:0] base;

    // Bits at or above ptr_i. If none of those requests, fall back to the
    // whole vector. That fallback is the wrap from the top index back to 0.
    assign mask_hi = ~((NUM_REQ'(1) << ptr_i) - NUM_REQ'(1));
    assign req_hi  = req_i & mask_hi;
    assign base    = ((mode_i == ARB_RR) && (|req_hi)) ? req_hi : req_i;

    // Isolate the lowest set bit of the candidate set.
    assign winner_onehot_o = base & (~base + NUM_REQ'(1));
    assign winner_idx_o    = IDX_W'(onehot_to_idx(MAX_MASTERS'(winner_onehot_o)));

endmodule

// File: rtl/axi_aw_rr_arbiter.sv
// ----------------------------------------------------------------------------
// axi_aw_rr_arbiter
// N-master arbiter for the AXI write-address channel. A grant is locked from
// selection through the AW handshake. With LOCK_W_BURST, the lock also lasts
// until the WLAST beat, so that AW and W ownership stay consistent.
//   ACLK / ARESETN    clock, synchronous active-low reset
//   awvalid_in        per-master AWVALID
//   aw_hs, w_last_hs  handshakes of the muxed AW channel and the muxed W
//                     channel (WLAST)
//   Channel_Granted   controller permits a new arbitration
//   Channel_Request   Channel_Granted & |awvalid_in
//   grant_valid / grant_onehot / Selected_Master   current owner
//   w_owner_busy      W burst of the owner still outstanding
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no owner; arbitrate when Channel_Request is asserted
//   AW_WAIT | owner selected; waiting for the AW handshake
//   W_WAIT  | AW done; waiting for WLAST of the owner's burst
// ----------------------------------------------------------------------------
module axi_aw_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 4,
    parameter int unsigned MASTER_ID_W  = $clog2(NUM_MASTERS),
    parameter arb_mode_e   ARB_MODE     = ARB_RR,
    parameter bit          LOCK_W_BURST = 1'b1
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [NUM_MASTERS-1:0] awvalid_in,
    input  logic                   aw_hs,
    input  logic                   w_last_hs,
    input  logic                   Channel_Granted,
    output logic                   Channel_Request,
    output logic                   grant_valid,
    output logic [NUM_MASTERS-1:0] grant_onehot,
    output logic [MASTER_ID_W-1:0] Selected_Master,
    output logic                   w_owner_busy
);

    aw_arb_state_e            state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_oh_q, grant_oh_d;
    logic [MASTER_ID_W-1:0]   sel_q, sel_d;
    logic [MASTER_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                     w_done_early_q, w_done_early_d;

    logic [NUM_MASTERS-1:0]   pick_oh;
    logic [MASTER_ID_W-1:0]   pick_idx;
    logic [MASTER_ID_W-1:0]   owner_next;

    rr_priority_picker #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (MASTER_ID_W)
    ) u_picker (
        .req_i           (awvalid_in),
        .ptr_i           (rr_ptr_q),
        .mode_i          (ARB_MODE),
        .winner_onehot_o (pick_oh),
        .winner_idx_o    (pick_idx)
    );

    assign Channel_Request = Channel_Granted & (|awvalid_in);
    assign grant_valid     = (state_q != IDLE);
    assign grant_onehot    = grant_oh_q;
    assign Selected_Master = sel_q;
    assign w_owner_busy    = (state_q == W_WAIT);

    // NUM_MASTERS need not be a power of two, so the wrap is explicit.
    assign owner_next = (sel_q == MASTER_ID_W'(NUM_MASTERS - 1)) ? '0
                                                                 : sel_q + MASTER_ID_W'(1);

    always_comb begin
        state_d        = state_q;
        grant_oh_d     = grant_oh_q;
        sel_d          = sel_q;
        rr_ptr_d       = rr_ptr_q;
        w_done_early_d = w_done_early_q;

        unique case (state_q)
            IDLE: begin
                if (Channel_Request) begin
                    grant_oh_d = pick_oh;
                    sel_d      = pick_idx;
                    state_d    = AW_WAIT;
                end
            end
            AW_WAIT: begin
                if (aw_hs) begin
                    if (ARB_MODE == ARB_RR) rr_ptr_d = owner_next;
                    w_done_early_d = 1'b0;
                    if (!LOCK_W_BURST || w_last_hs || w_done_early_q) begin
                        state_d    = IDLE;
                        grant_oh_d = '0;
                    end else begin
                        state_d = W_WAIT;
                    end
                end else if (w_last_hs && LOCK_W_BURST) begin
                    // The W burst finished before its address. Remember this
                    // so that the AW handshake can release the grant directly.
                    w_done_early_d = 1'b1;
                end
            end
            W_WAIT: begin
                if (w_last_hs) begin
                    state_d    = IDLE;
                    grant_oh_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_oh_d = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q        <= IDLE;
            grant_oh_q     <= '0;
            sel_q          <= '0;
            rr_ptr_q       <= '0;
            w_done_early_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_oh_q     <= grant_oh_d;
            sel_q          <= sel_d;
            rr_ptr_q       <= rr_ptr_d;
            w_done_early_q <= w_done_early_d;
        end
    end

endmodule

// File: tb/tb_axi_aw_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_aw_rr_arbiter
// Directed bench. The main instance uses round-robin with the W lock. A second
// instance uses fixed priority and releases at the AW handshake.
// ----------------------------------------------------------------------------
module tb_axi_aw_rr_arbiter;
    import axi_arb_pkg::*;

    logic       ACLK = 1'b0;
    logic       ARESETN;

    logic [3:0] awvalid, fx_awvalid;
    logic       aw_hs, w_last, cg;
    logic       fx_aw_hs, fx_w_last, fx_cg;

    logic       creq, gv, busy;
    logic [3:0] goh;
    logic [1:0] sel;
    logic       fx_creq, fx_gv, fx_busy;
    logic [3:0] fx_goh;
    logic [1:0] fx_sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK = ~ACLK;

    axi_aw_rr_arbiter #(
        .NUM_MASTERS(4), .ARB_MODE(ARB_RR), .LOCK_W_BURST(1'b1)
    ) u_dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .awvalid_in(awvalid), .aw_hs(aw_hs),
        .w_last_hs(w_last), .Channel_Granted(cg), .Channel_Request(creq),
        .grant_valid(gv), .grant_onehot(goh), .Selected_Master(sel),
        .w_owner_busy(busy)
    );

    axi_aw_rr_arbiter #(
        .NUM_MASTERS(4), .ARB_MODE(ARB_FIXED), .LOCK_W_BURST(1'b0)
    ) u_dut_fx (
        .ACLK(ACLK), .ARESETN(ARESETN), .awvalid_in(fx_awvalid), .aw_hs(fx_aw_hs),
        .w_last_hs(fx_w_last), .Channel_Granted(fx_cg), .Channel_Request(fx_creq),
        .grant_valid(fx_gv), .grant_onehot(fx_goh), .Selected_Master(fx_sel),
        .w_owner_busy(fx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic exp_gv, input int exp_idx);
        chk({tag, ".gv"}, 32'(gv), 32'(exp_gv));
        chk({tag, ".sel"}, 32'(sel), 32'(exp_idx));
        chk({tag, ".oh"}, 32'(goh), exp_gv ? (32'd1 << exp_idx) : 32'd0);
    endtask

    initial begin
        ARESETN    = 1'b0;
        awvalid    = 4'b1111; aw_hs = 1'b0; w_last = 1'b0; cg = 1'b1;
        fx_awvalid = 4'b1111; fx_aw_hs = 1'b0; fx_w_last = 1'b0; fx_cg = 1'b1;

        // Reset held for 3 cycles with all masters requesting.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.gv", 32'(gv), 32'd0);
            chk("rst.oh", 32'(goh), 32'd0);
            chk("rst.sel", 32'(sel), 32'd0);
            chk("rst.busy", 32'(busy), 32'd0);
        end
        ARESETN = 1'b1;
        awvalid = 4'b0000; cg = 1'b0;
        fx_awvalid = 4'b0000; fx_cg = 1'b0;
        step();
        chk("idle.creq", 32'(creq), 32'd0);
        chk("idle.gv", 32'(gv), 32'd0);

        // Fixed priority: 1010 -> master 1, held until AW; release at AW.
        fx_awvalid = 4'b1010; fx_cg = 1'b1;
        step();
        chk("fx.gv", 32'(fx_gv), 32'd1);
        chk("fx.oh", 32'(fx_goh), 32'b0010);
        chk("fx.sel", 32'(fx_sel), 32'd1);
        fx_awvalid = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("fx.hold", 32'(fx_goh), 32'b0010);
        end
        fx_aw_hs = 1'b1;
        step();
        fx_aw_hs = 1'b0;
        chk("fx.rel.gv", 32'(fx_gv), 32'd0);
        chk("fx.rel.oh", 32'(fx_goh), 32'd0);
        chk("fx.rel.sel", 32'(fx_sel), 32'd1);
        chk("fx.busy", 32'(fx_busy), 32'd0);
        fx_awvalid = 4'b0101;
        step();
        chk("fx.low.oh", 32'(fx_goh), 32'b0001);
        chk("fx.low.sel", 32'(fx_sel), 32'd0);
        fx_aw_hs = 1'b1;
        step();
        fx_aw_hs = 1'b0; fx_awvalid = 4'b0000; fx_cg = 1'b0;

        // Round-robin with all four masters requesting: 0,1,2,3,0.
        awvalid = 4'b1111; cg = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_grant("rr", 1'b1, k % 4);
            aw_hs = 1'b1; w_last = 1'b1;
            step();
            aw_hs = 1'b0; w_last = 1'b0;
            chk("rr.rel", 32'(gv), 32'd0);
        end
        // The pointer is now 1.

        // W lock: AW at t, WLAST at t+5.
        awvalid = 4'b0100;
        step();
        chk_grant("lk", 1'b1, 2);
        aw_hs = 1'b1;
        step();
        aw_hs = 1'b0;
        chk("lk.busy1", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lk.busy", 32'(busy), 32'd1);
            chk("lk.gv", 32'(gv), 32'd1);
        end
        w_last = 1'b1;
        step();
        w_last = 1'b0;
        chk("lk.t6.gv", 32'(gv), 32'd0);
        chk("lk.t6.busy", 32'(busy), 32'd0);
        step();
        chk_grant("lk.t7", 1'b1, 2);
        aw_hs = 1'b1; w_last = 1'b1;
        step();
        aw_hs = 1'b0; w_last = 1'b0;
        // The pointer is now 3.

        // W before AW: pointer 3 with requests 1001 -> master 3.
        awvalid = 4'b1001;
        step();
        chk_grant("wb", 1'b1, 3);
        w_last = 1'b1;
        step();
        w_last = 1'b0;
        chk("wb.busy1", 32'(busy), 32'd0);
        chk("wb.gv1", 32'(gv), 32'd1);
        step();
        chk("wb.busy2", 32'(busy), 32'd0);
        aw_hs = 1'b1;
        step();
        aw_hs = 1'b0;
        chk("wb.gv3", 32'(gv), 32'd0);
        chk("wb.busy3", 32'(busy), 32'd0);
        // The pointer wrapped 3 -> 0, and the early-done flag must be clear.
        step();
        chk_grant("wrap", 1'b1, 0);
        aw_hs = 1'b1;
        step();
        aw_hs = 1'b0;
        chk("wb.clr.busy", 32'(busy), 32'd1);
        w_last = 1'b1;
        step();
        w_last = 1'b0;
        chk("wb.clr.gv", 32'(gv), 32'd0);
        // The pointer is now 1.

        // Channel_Granted dropped during AW_WAIT, then reset during W_WAIT.
        awvalid = 4'b0010;
        step();
        chk_grant("cg", 1'b1, 1);
        cg = 1'b0; awvalid = 4'b1101;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_grant("cg.hold", 1'b1, 1);
        end
        chk("cg.creq", 32'(creq), 32'd0);
        aw_hs = 1'b1;
        step();
        aw_hs = 1'b0;
        chk("cg.busy", 32'(busy), 32'd1);
        ARESETN = 1'b0;
        step();
        ARESETN = 1'b1;
        chk_grant("mrst", 1'b0, 0);
        chk("mrst.busy", 32'(busy), 32'd0);
        // The pointer resets to 0, so all requesting -> master 0.
        awvalid = 4'b1111; cg = 1'b1;
        step();
        chk_grant("mrst.ptr", 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
